ring3_burst_arbiter: RTL

- Shares one 3-state ring stepper (states S0→S1→S2→S0, one advance per step pulse) between NREQ requesters.
- Each requester asks for a burst of L step pulses. The block arbitrates round-robin, grants one requester, then drives exactly L steps into the ring. It reports the final ring state and the number of S2→S0 wraps that occurred during the burst.
- Sits between the requester logic and the ring datapath. It is the only driver of the ring's step input.

---
 rtl/ring3_pkg.sv | 29 ++
 rtl/ring3_stepper.sv | 27 ++
 rtl/ring3_burst_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ring3_pkg.sv
// Shared types for the ring3 burst arbiter: ring encoding, arbiter FSM states
// and the ring next-state function.
package ring3_pkg;

   typedef enum logic [1:0] {
      RING_S0 = 2'b00,
      RING_S1 = 2'b01,
      RING_S2 = 2'b10
   } ring_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_GRANT  = 2'b01,
      ARB_STEP   = 2'b10,
      ARB_REPORT = 2'b11
   } arb_state_t;

   // S2 and the illegal 11 encoding both fall back to S0.
   function automatic logic [1:0] ring_next(input logic [1:0] cur);
      logic [1:0] nxt;
      case (cur)
         RING_S0: nxt = RING_S1;
         RING_S1: nxt = RING_S2;
         default: nxt = RING_S0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ring3_stepper.sv
// Three-state ring S0->S1->S2->S0 advancing once per step; wrap flags the
// cycle whose step takes the ring from S2 back to S0.
module ring3_stepper
   import ring3_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [1:0] state,
   output logic       wrap
);

   logic [1:0] state_q;

   // Ring register, advanced on every step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RING_S0;
      end else if (step) begin
         state_q <= ring_next(state_q);
      end
   end

   assign state = state_q;
   assign wrap  = step && (state_q == RING_S2);

endmodule

// File: rtl/ring3_burst_arbiter.sv
// Round-robin arbiter that grants one requester at a time and drives its
// requested number of step pulses into the shared ring stepper.
module ring3_burst_arbiter
   import ring3_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int LEN_W = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] len,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  ring_step,
   output logic [1:0]            ring_state,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic [LEN_W-1:0]      wraps,
   output logic                  aborted
);

   // Returns {found, index}: first asserted request after last, wrapping.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  last);
      logic [IDW:0] res;
      int           cand;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = (int'(last) + k) % NREQ;
         if (r[IDW'(cand)]) begin
            res = {1'b1, IDW'(cand)};
         end
      end
      return res;
   endfunction

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   idx_q, idx_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] wcnt_q, wcnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             busy_q, busy_d;
   logic             step_q, step_d;
   logic             done_q, done_d;
   logic [IDW-1:0]   done_id_q, done_id_d;
   logic [LEN_W-1:0] wraps_q, wraps_d;
   logic             aborted_q, aborted_d;

   logic [IDW:0]     pick_s;
   logic [LEN_W-1:0] len_a [NREQ];
   logic [LEN_W-1:0] wcnt_inc_s;
   logic             wrap_s;

   ring3_stepper u_ring (
      .clk   (clk),
      .rst   (rst),
      .step  (step_q),
      .state (ring_state),
      .wrap  (wrap_s)
   );

   // Unpack the flat length bus into one entry per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         len_a[i] = len[i*LEN_W +: LEN_W];
      end
   end

   assign pick_s     = rr_pick(req, last_q);
   assign wcnt_inc_s = (wrap_s && (wcnt_q != {LEN_W{1'b1}})) ? wcnt_q + LEN_W'(1) : wcnt_q;

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      rem_d     = rem_q;
      wcnt_d    = wcnt_q;
      gnt_d     = gnt_q;
      step_d    = 1'b0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      wraps_d   = wraps_q;
      aborted_d = aborted_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_s[IDW]) begin
               idx_d   = pick_s[IDW-1:0];
               rem_d   = len_a[pick_s[IDW-1:0]];
               wcnt_d  = '0;
               gnt_d   = NREQ'(1) << pick_s[IDW-1:0];
               state_d = ARB_GRANT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (!req[idx_q] || (rem_q == LEN_W'(0))) begin
               state_d   = ARB_REPORT;
               done_d    = 1'b1;
               done_id_d = idx_q;
               wraps_d   = wcnt_q;
               aborted_d = !req[idx_q];
            end else begin
               state_d = ARB_STEP;
               step_d  = 1'b1;
            end
         end
         ARB_STEP: begin
            // The step issued this cycle lands on the closing edge, so count it now.
            wcnt_d = wcnt_inc_s;
            rem_d  = rem_q - LEN_W'(1);
            if (!req[idx_q] || (rem_q == LEN_W'(1))) begin
               state_d   = ARB_REPORT;
               done_d    = 1'b1;
               done_id_d = idx_q;
               wraps_d   = wcnt_inc_s;
               aborted_d = !req[idx_q];
            end else begin
               state_d = ARB_STEP;
               step_d  = 1'b1;
            end
         end
         ARB_REPORT: begin
            last_d  = idx_q;
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         idx_q     <= '0;
         last_q    <= IDW'(NREQ - 1);
         rem_q     <= '0;
         wcnt_q    <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         step_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         wraps_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         rem_q     <= rem_d;
         wcnt_q    <= wcnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         step_q    <= step_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         wraps_q   <= wraps_d;
         aborted_q <= aborted_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign ring_step = step_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign wraps     = wraps_q;
   assign aborted   = aborted_q;

endmodule
